// File: rtl/tl_ul_a_arbiter.sv
// tl_ul_a_arbiter: round-robin arbiter sharing one TileLink-UL A channel
// among NREQ requesters, with burst locking, one-outstanding-per-source
// tracking and D-channel routing by d_source.
// Optional watchdog: define TL_UL_A_ARBITER_WDOG_EN to build it.
module tl_ul_a_arbiter #(
   parameter int          NREQ       = 4,
   parameter int          BEAT_BYTES = 4,
   parameter logic [15:0] WDOG_LIMIT = 16'hFFFF
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [NREQ-1:0]    req_valid,
   output logic [NREQ-1:0]    req_ready,
   input  logic [3*NREQ-1:0]  req_opcode,
   input  logic [4*NREQ-1:0]  req_size,
   input  logic [32*NREQ-1:0] req_address,
   input  logic [32*NREQ-1:0] req_data,
   output logic               a_valid,
   input  logic               a_ready,
   output logic [2:0]         a_opcode,
   output logic [3:0]         a_size,
   output logic [1:0]         a_source,
   output logic [31:0]        a_address,
   output logic [31:0]        a_data,
   input  logic               d_valid,
   output logic               d_ready,
   input  logic [2:0]         d_opcode,
   input  logic [3:0]         d_size,
   input  logic [1:0]         d_source,
   input  logic [31:0]        d_data,
   output logic [NREQ-1:0]    rsp_valid,
   input  logic [NREQ-1:0]    rsp_ready,
   output logic [2:0]         rsp_opcode,
   output logic [31:0]        rsp_data,
   output logic               err_unexpected_d,
   output logic               wdog_timeout
);

   localparam int BEAT_LG = $clog2(BEAT_BYTES);

   typedef enum logic {IDLE, BURST} state_t;

   state_t          state_reg;
   logic [1:0]      rr_ptr_reg, gnt_reg;
   logic [3:0]      a_rem_reg, d_rem_reg;
   logic [NREQ-1:0] outstanding_reg, eligible;
   logic            err_reg;

   logic [1:0]  win, sel, ptr_inc;
   logic        any_elig;
   logic [2:0]  sel_opcode;
   logic [3:0]  sel_size;
   logic [31:0] sel_address, sel_data;
   logic [4:0]  a_beats, d_beats;
   logic        a_hs, a_last, d_hs, d_last;
   logic [3:0]  out_ext, valid_ext, rready_ext, out_next_ext;

   // Number of beats for a transfer: 2^(size-lg) for multi-beat kinds, clamped at 16.
   function automatic logic [4:0] beats_of(input logic multi, input logic [3:0] sz);
      logic [4:0] n;
      n = 5'd1;
      if (multi && (int'(sz) > BEAT_LG)) begin
         if (int'(sz) - BEAT_LG >= 4) n = 5'd16;
         else n = 5'd1 << (int'(sz) - BEAT_LG);
      end
      return n;
   endfunction

   assign eligible = req_valid & ~outstanding_reg;
   assign any_elig = |eligible;

   // Pad per-source vectors to the full 2-bit source space; unknown sources drain and look idle.
   always_comb begin
      out_ext                = '0;
      out_ext[NREQ-1:0]      = outstanding_reg;
      valid_ext              = '0;
      valid_ext[NREQ-1:0]    = req_valid;
      rready_ext             = '1;
      rready_ext[NREQ-1:0]   = rsp_ready;
   end

   // Round-robin search starting at rr_ptr, lowest index first after the pointer.
   always_comb begin : rr_search
      int  cand;
      logic found;
      cand  = 0;
      found = 1'b0;
      win   = rr_ptr_reg;
      for (int k = 0; k < NREQ; k++) begin
         cand = int'(rr_ptr_reg) + k;
         if (cand >= NREQ) cand = cand - NREQ;
         for (int i = 0; i < NREQ; i++) begin
            if (!found && cand == i && eligible[i]) begin
               win   = 2'(i);
               found = 1'b1;
            end
         end
      end
   end

   assign sel     = (state_reg == BURST) ? gnt_reg : win;
   assign ptr_inc = (sel == 2'(NREQ - 1)) ? 2'd0 : sel + 2'd1;

   // A-channel field mux from the selected requester.
   always_comb begin
      sel_opcode  = '0;
      sel_size    = '0;
      sel_address = '0;
      sel_data    = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (sel == 2'(i)) begin
            sel_opcode  = req_opcode[i*3 +: 3];
            sel_size    = req_size[i*4 +: 4];
            sel_address = req_address[i*32 +: 32];
            sel_data    = req_data[i*32 +: 32];
         end
      end
   end

   assign a_valid   = !reset && ((state_reg == BURST) ? valid_ext[gnt_reg] : any_elig);
   assign a_opcode  = reset ? 3'd0  : sel_opcode;
   assign a_size    = reset ? 4'd0  : sel_size;
   assign a_source  = reset ? 2'd0  : sel;
   assign a_address = reset ? 32'd0 : sel_address;
   assign a_data    = reset ? 32'd0 : sel_data;

   assign a_hs    = a_valid && a_ready;
   assign a_beats = beats_of(sel_opcode == 3'd0 || sel_opcode == 3'd1, sel_size);
   assign a_last  = a_hs && ((state_reg == IDLE) ? (a_beats == 5'd1) : (a_rem_reg == 4'd1));

   assign d_ready    = !reset && rready_ext[d_source];
   assign d_hs       = d_valid && d_ready;
   assign d_beats    = beats_of(d_opcode == 3'd1, d_size);
   assign d_last     = d_hs && ((d_rem_reg == 4'd0) ? (d_beats == 5'd1) : (d_rem_reg == 4'd1));
   assign rsp_opcode = reset ? 3'd0  : d_opcode;
   assign rsp_data   = reset ? 32'd0 : d_data;

   genvar gi;
   generate
      for (gi = 0; gi < NREQ; gi++) begin : g_port
         assign req_ready[gi] = !reset && a_ready && (sel == 2'(gi)) &&
                                ((state_reg == BURST) || any_elig);
         assign rsp_valid[gi] = !reset && d_valid && (d_source == 2'(gi));
      end
   endgenerate

   // Outstanding update: set by last A beat, cleared by last D beat.
   always_comb begin
      out_next_ext = out_ext;
      if (d_last) out_next_ext[d_source] = 1'b0;
      if (a_last) out_next_ext[sel]      = 1'b1;
   end

   // Arbiter state machine, pointer, beat counters and outstanding bits.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg       <= IDLE;
         rr_ptr_reg      <= '0;
         gnt_reg         <= '0;
         a_rem_reg       <= '0;
         d_rem_reg       <= '0;
         outstanding_reg <= '0;
      end else begin
         case (state_reg)
            IDLE: if (a_hs) begin
               gnt_reg <= win;
               if (a_beats > 5'd1) begin
                  state_reg <= BURST;
                  a_rem_reg <= 4'(a_beats - 5'd1);
               end
            end
            BURST: if (a_hs) begin
               if (a_rem_reg == 4'd1) state_reg <= IDLE;
               a_rem_reg <= a_rem_reg - 4'd1;
            end
            default: state_reg <= IDLE;
         endcase
         if (a_last) rr_ptr_reg <= ptr_inc;
         if (d_hs) begin
            if (d_rem_reg == 4'd0)
               d_rem_reg <= (d_beats > 5'd1) ? 4'(d_beats - 5'd1) : 4'd0;
            else
               d_rem_reg <= d_rem_reg - 4'd1;
         end
         outstanding_reg <= out_next_ext[NREQ-1:0];
      end
   end

   // Sticky flag for a D beat arriving on a source with nothing outstanding.
   always_ff @(posedge clock) begin
      if (reset)                            err_reg <= 1'b0;
      else if (d_valid && !out_ext[d_source]) err_reg <= 1'b1;
   end
   assign err_unexpected_d = err_reg;

`ifdef TL_UL_A_ARBITER_WDOG_EN
   logic [15:0] wdog_cnt_reg;
   logic        wdog_reg;

   // Count stalled cycles while something is outstanding; flag sticks once the limit is hit.
   always_ff @(posedge clock) begin
      if (reset) begin
         wdog_cnt_reg <= '0;
         wdog_reg     <= 1'b0;
      end else begin
         if (d_hs || outstanding_reg == '0) wdog_cnt_reg <= '0;
         else if (wdog_cnt_reg != WDOG_LIMIT) wdog_cnt_reg <= wdog_cnt_reg + 16'd1;
         if (wdog_cnt_reg == WDOG_LIMIT) wdog_reg <= 1'b1;
      end
   end
   assign wdog_timeout = wdog_reg;
`else
   logic unused_wdog_limit;
   assign unused_wdog_limit = ^WDOG_LIMIT;
   assign wdog_timeout      = 1'b0;
`endif

endmodule

// File: tb/tb_tl_ul_a_arbiter.sv
// Testbench for tl_ul_a_arbiter: table-driven cycle vectors plus hand-written
// sequences for outstanding blocking, watchdog and mid-burst reset.
module tb_tl_ul_a_arbiter;
   localparam int NREQ = 4;
`ifdef TL_UL_A_ARBITER_WDOG_EN
   localparam logic WDOG_ON = 1'b1;
`else
   localparam logic WDOG_ON = 1'b0;
`endif

   logic clock = 1'b0;
   logic reset;
   logic [NREQ-1:0]    req_valid, req_ready;
   logic [3*NREQ-1:0]  req_opcode;
   logic [4*NREQ-1:0]  req_size;
   logic [32*NREQ-1:0] req_address, req_data;
   logic a_valid, a_ready;
   logic [2:0] a_opcode;
   logic [3:0] a_size;
   logic [1:0] a_source;
   logic [31:0] a_address, a_data;
   logic d_valid, d_ready;
   logic [2:0] d_opcode;
   logic [3:0] d_size;
   logic [1:0] d_source;
   logic [31:0] d_data;
   logic [NREQ-1:0] rsp_valid, rsp_ready;
   logic [2:0] rsp_opcode;
   logic [31:0] rsp_data;
   logic err_unexpected_d, wdog_timeout;

   always #5 clock = ~clock;

   tl_ul_a_arbiter #(.NREQ(NREQ), .BEAT_BYTES(4), .WDOG_LIMIT(16'd8)) dut (
      .clock(clock), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
      .req_size(req_size), .req_address(req_address), .req_data(req_data),
      .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_size(a_size),
      .a_source(a_source), .a_address(a_address), .a_data(a_data),
      .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_size(d_size),
      .d_source(d_source), .d_data(d_data),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_opcode(rsp_opcode),
      .rsp_data(rsp_data), .err_unexpected_d(err_unexpected_d),
      .wdog_timeout(wdog_timeout)
   );

   typedef struct packed {
      logic [3:0]  rv;
      logic [11:0] op;
      logic [15:0] sz;
      logic        ar;
      logic        dv;
      logic [1:0]  ds;
      logic [2:0]  dop;
      logic [3:0]  dsz;
      logic [3:0]  rr;
      logic        eav;
      logic [1:0]  esrc;
      logic [3:0]  erdy;
      logic [3:0]  ersp;
      logic        edr;
      logic        eerr;
   } vec_t;

   localparam logic [11:0] OP_GET = {3'd4, 3'd4, 3'd4, 3'd4};
   localparam logic [11:0] OP_B   = {3'd4, 3'd4, 3'd0, 3'd4};
   localparam logic [15:0] SZ_2   = 16'h2222;
   localparam logic [15:0] SZ_B   = 16'h2242;

   int pass_cnt = 0;
   int total_cnt = 0;
   vec_t tbl[21];

   function automatic vec_t mk(logic [3:0] rv, logic [11:0] op, logic [15:0] sz, logic ar,
                               logic dv, logic [1:0] ds, logic [2:0] dop, logic [3:0] dsz,
                               logic [3:0] rr, logic eav, logic [1:0] esrc, logic [3:0] erdy,
                               logic [3:0] ersp, logic edr, logic eerr);
      vec_t v;
      v = '{rv, op, sz, ar, dv, ds, dop, dsz, rr, eav, esrc, erdy, ersp, edr, eerr};
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
      else pass_cnt++;
   endtask

   task automatic drive(input vec_t v);
      req_valid  = v.rv;
      req_opcode = v.op;
      req_size   = v.sz;
      a_ready    = v.ar;
      d_valid    = v.dv;
      d_source   = v.ds;
      d_opcode   = v.dop;
      d_size     = v.dsz;
      d_data     = 32'hA500_0000 | 32'(v.ds);
      rsp_ready  = v.rr;
   endtask

   task automatic check_vec(input string tag, input vec_t v);
      logic [11:0] opv;
      opv = v.op;
      chk({tag, " a_valid"}, a_valid, v.eav);
      if (v.eav) begin
         chk({tag, " a_source"}, a_source, v.esrc);
         chk({tag, " a_address"}, a_address, 32'h1000 * (32'(v.esrc) + 1));
         chk({tag, " a_data"}, a_data, 32'hD000_0000 + 32'(v.esrc));
         chk({tag, " a_opcode"}, a_opcode, opv[v.esrc*3 +: 3]);
      end
      chk({tag, " req_ready"}, req_ready, v.erdy);
      chk({tag, " rsp_valid"}, rsp_valid, v.ersp);
      chk({tag, " d_ready"}, d_ready, v.edr);
      if (v.dv) chk({tag, " rsp_data"}, rsp_data, 32'hA500_0000 | 32'(v.ds));
      chk({tag, " err"}, err_unexpected_d, v.eerr);
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   initial begin
      // Round robin (0..3 then 0 again), burst lock with a_ready toggling,
      // multi-beat D routing with a stall, unexpected D.
      tbl[0]  = mk(4'hF, OP_GET, SZ_2, 1, 0, 0, 0, 2, 4'hF, 1, 0, 4'h1, 4'h0, 1, 0);
      tbl[1]  = mk(4'hF, OP_GET, SZ_2, 1, 1, 0, 0, 2, 4'hF, 1, 1, 4'h2, 4'h1, 1, 0);
      tbl[2]  = mk(4'hF, OP_GET, SZ_2, 1, 1, 1, 0, 2, 4'hF, 1, 2, 4'h4, 4'h2, 1, 0);
      tbl[3]  = mk(4'hF, OP_GET, SZ_2, 1, 1, 2, 0, 2, 4'hF, 1, 3, 4'h8, 4'h4, 1, 0);
      tbl[4]  = mk(4'hF, OP_GET, SZ_2, 1, 1, 3, 0, 2, 4'hF, 1, 0, 4'h1, 4'h8, 1, 0);
      tbl[5]  = mk(4'h0, OP_GET, SZ_2, 1, 1, 0, 0, 2, 4'hF, 0, 0, 4'h0, 4'h1, 1, 0);
      tbl[6]  = mk(4'h6, OP_B,   SZ_B, 0, 0, 0, 0, 2, 4'hF, 1, 1, 4'h0, 4'h0, 1, 0);
      tbl[7]  = mk(4'h6, OP_B,   SZ_B, 1, 0, 0, 0, 2, 4'hF, 1, 1, 4'h2, 4'h0, 1, 0);
      tbl[8]  = mk(4'h6, OP_B,   SZ_B, 0, 0, 0, 0, 2, 4'hF, 1, 1, 4'h0, 4'h0, 1, 0);
      tbl[9]  = mk(4'h6, OP_B,   SZ_B, 1, 0, 0, 0, 2, 4'hF, 1, 1, 4'h2, 4'h0, 1, 0);
      tbl[10] = mk(4'h6, OP_B,   SZ_B, 0, 0, 0, 0, 2, 4'hF, 1, 1, 4'h0, 4'h0, 1, 0);
      tbl[11] = mk(4'h6, OP_B,   SZ_B, 1, 0, 0, 0, 2, 4'hF, 1, 1, 4'h2, 4'h0, 1, 0);
      tbl[12] = mk(4'h6, OP_B,   SZ_B, 1, 0, 0, 0, 2, 4'hF, 1, 1, 4'h2, 4'h0, 1, 0);
      tbl[13] = mk(4'h6, OP_B,   SZ_B, 1, 0, 0, 0, 2, 4'hF, 1, 2, 4'h4, 4'h0, 1, 0);
      tbl[14] = mk(4'h0, OP_B,   SZ_B, 1, 1, 1, 0, 2, 4'hF, 0, 0, 4'h0, 4'h2, 1, 0);
      tbl[15] = mk(4'h0, OP_GET, SZ_2, 1, 1, 2, 1, 3, 4'hB, 0, 0, 4'h0, 4'h4, 0, 0);
      tbl[16] = mk(4'h0, OP_GET, SZ_2, 1, 1, 2, 1, 3, 4'hF, 0, 0, 4'h0, 4'h4, 1, 0);
      tbl[17] = mk(4'h4, OP_GET, SZ_2, 0, 1, 2, 1, 3, 4'hF, 0, 0, 4'h0, 4'h4, 1, 0);
      tbl[18] = mk(4'h4, OP_GET, SZ_2, 0, 0, 0, 0, 2, 4'hF, 1, 2, 4'h0, 4'h0, 1, 0);
      tbl[19] = mk(4'h0, OP_GET, SZ_2, 0, 1, 3, 0, 2, 4'hF, 0, 0, 4'h0, 4'h8, 1, 0);
      tbl[20] = mk(4'h0, OP_GET, SZ_2, 0, 0, 0, 0, 2, 4'hF, 0, 0, 4'h0, 4'h0, 1, 1);

      for (int i = 0; i < NREQ; i++) begin
         req_address[i*32 +: 32] = 32'h1000 * (32'(i) + 1);
         req_data[i*32 +: 32]    = 32'hD000_0000 + 32'(i);
      end

      // Reset with every requester valid and a D beat pending: all outputs stay low.
      reset = 1'b1;
      drive(mk(4'hF, OP_GET, SZ_2, 1, 1, 0, 0, 2, 4'hF, 0, 0, 0, 0, 0, 0));
      step();
      for (int c = 0; c < 3; c++) begin
         #3;
         chk($sformatf("reset%0d a_valid", c), a_valid, 1'b0);
         chk($sformatf("reset%0d req_ready", c), req_ready, 4'h0);
         chk($sformatf("reset%0d rsp_valid", c), rsp_valid, 4'h0);
         chk($sformatf("reset%0d d_ready", c), d_ready, 1'b0);
         chk($sformatf("reset%0d err", c), err_unexpected_d, 1'b0);
         chk($sformatf("reset%0d wdog", c), wdog_timeout, 1'b0);
         step();
      end
      reset = 1'b0;

      for (int i = 0; i < 21; i++) begin
         drive(tbl[i]);
         #3;
         check_vec($sformatf("row%0d", i), tbl[i]);
         $display("row %0d: a_valid=%0d a_source=%0d req_ready=%b rsp_valid=%b err=%0d",
                  i, a_valid, a_source, req_ready, rsp_valid, err_unexpected_d);
         step();
      end

      // Outstanding block: req0 accepted, D held off, blocked through the D handshake cycle.
      drive(mk(4'h1, OP_GET, SZ_2, 1, 0, 0, 0, 2, 4'hF, 0, 0, 0, 0, 0, 0));
      #3;
      chk("ob_grant a_valid", a_valid, 1'b1);
      chk("ob_grant a_source", a_source, 2'd0);
      chk("ob_grant req_ready", req_ready, 4'h1);
      step();
      for (int c = 0; c < 2; c++) begin
         #3;
         chk($sformatf("ob_wait%0d a_valid", c), a_valid, 1'b0);
         chk($sformatf("ob_wait%0d req_ready", c), req_ready, 4'h0);
         step();
      end
      drive(mk(4'h1, OP_GET, SZ_2, 1, 1, 0, 0, 2, 4'hF, 0, 0, 0, 0, 0, 0));
      #3;
      chk("ob_dhs a_valid", a_valid, 1'b0);
      chk("ob_dhs rsp_valid", rsp_valid, 4'h1);
      chk("ob_dhs d_ready", d_ready, 1'b1);
      step();
      drive(mk(4'h1, OP_GET, SZ_2, 1, 0, 0, 0, 2, 4'hF, 0, 0, 0, 0, 0, 0));
      #3;
      chk("ob_regrant a_valid", a_valid, 1'b1);
      chk("ob_regrant a_source", a_source, 2'd0);
      chk("ob_regrant req_ready", req_ready, 4'h1);
      chk("ob_regrant err sticky", err_unexpected_d, 1'b1);
      $display("outstanding block: regrant a_source=%0d", a_source);
      step();

      // Watchdog: req0 outstanding with D held off.
      drive(mk(4'h0, OP_GET, SZ_2, 1, 0, 0, 0, 2, 4'hF, 0, 0, 0, 0, 0, 0));
      repeat (3) step();
      #3;
      chk("wdog early", wdog_timeout, 1'b0);
      step();
      repeat (8) step();
      #3;
      chk("wdog late", wdog_timeout, WDOG_ON);
      step();
      drive(mk(4'h0, OP_GET, SZ_2, 1, 1, 0, 0, 2, 4'hF, 0, 0, 0, 0, 0, 0));
      step();
      drive(mk(4'h0, OP_GET, SZ_2, 1, 0, 0, 0, 2, 4'hF, 0, 0, 0, 0, 0, 0));
      step();
      #3;
      chk("wdog sticky", wdog_timeout, WDOG_ON);
      $display("watchdog: wdog_timeout=%0d", wdog_timeout);
      step();

      // Mid-burst reset: req3 starts an 8-beat put, burst lock holds, reset abandons it.
      drive(mk(4'h8, {3'd0, 3'd4, 3'd4, 3'd4}, 16'h5222, 1, 0, 0, 0, 2, 4'hF, 0, 0, 0, 0, 0, 0));
      #3;
      chk("mb_first a_valid", a_valid, 1'b1);
      chk("mb_first a_source", a_source, 2'd3);
      step();
      drive(mk(4'hF, {3'd0, 3'd4, 3'd4, 3'd4}, 16'h5222, 0, 0, 0, 0, 2, 4'hF, 0, 0, 0, 0, 0, 0));
      #3;
      chk("mb_lock a_valid", a_valid, 1'b1);
      chk("mb_lock a_source", a_source, 2'd3);
      step();
      reset   = 1'b1;
      a_ready = 1'b1;
      #3;
      chk("mb_reset a_valid", a_valid, 1'b0);
      chk("mb_reset req_ready", req_ready, 4'h0);
      step();
      reset = 1'b0;
      drive(mk(4'hF, OP_GET, SZ_2, 0, 0, 0, 0, 2, 4'hF, 0, 0, 0, 0, 0, 0));
      #3;
      chk("mb_after a_valid", a_valid, 1'b1);
      chk("mb_after a_source", a_source, 2'd0);
      chk("mb_after err", err_unexpected_d, 1'b0);
      chk("mb_after wdog", wdog_timeout, 1'b0);
      $display("mid-burst reset: first grant a_source=%0d", a_source);
      step();

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
